// File: rtl/vote_report_tx.sv
// rtl/vote_report_tx.sv - snapshots four vote tallies and sends them as a framed 8N1 serial report
module vote_report_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       report_req,
    input  logic [7:0] cand1_vote,
    input  logic [7:0] cand2_vote,
    input  logic [7:0] cand3_vote,
    input  logic [7:0] cand4_vote,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BYTE = 3'd5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [2:0]    byte_idx, byte_nxt;
    logic [7:0]    snap1, snap2, snap3, snap4;
    logic [7:0]    snap1_nxt, snap2_nxt, snap3_nxt, snap4_nxt;
    logic          tx_nxt, busy_nxt, done_nxt;
    logic [9:0]    sum;
    logic [7:0]    cur_byte;
    logic [2:0]    bit_inc;
    logic          baud_end;

    // Checksum covers the four tallies only; the header is excluded.
    assign sum      = {2'b00, snap1} + {2'b00, snap2} + {2'b00, snap3} + {2'b00, snap4};
    assign baud_end = (baud == BAUD_LAST);
    assign bit_inc  = bit_idx + 3'd1;

    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            3'd1:    cur_byte = snap1;
            3'd2:    cur_byte = snap2;
            3'd3:    cur_byte = snap3;
            3'd4:    cur_byte = snap4;
            3'd5:    cur_byte = sum[7:0];
            default: cur_byte = HEADER;
        endcase
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        snap1_nxt = snap1;
        snap2_nxt = snap2;
        snap3_nxt = snap3;
        snap4_nxt = snap4;
        tx_nxt    = tx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (report_req && mode) begin
                    snap1_nxt = cand1_vote;
                    snap2_nxt = cand2_vote;
                    snap3_nxt = cand3_vote;
                    snap4_nxt = cand4_vote;
                    state_nxt = START;
                    busy_nxt  = 1'b1;
                    tx_nxt    = 1'b0;
                    byte_nxt  = 3'd0;
                    bit_nxt   = 3'd0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                    tx_nxt    = cur_byte[0];
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_inc;
                        tx_nxt  = cur_byte[bit_inc];
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        byte_nxt  = 3'd0;
                    end else begin
                        // Next byte starts right after this stop bit, no idle gap.
                        byte_nxt  = byte_idx + 3'd1;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            snap1    <= 8'd0;
            snap2    <= 8'd0;
            snap3    <= 8'd0;
            snap4    <= 8'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud     <= baud_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            snap1    <= snap1_nxt;
            snap2    <= snap2_nxt;
            snap3    <= snap3_nxt;
            snap4    <= snap4_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_vote_report_tx.sv
// tb/tb_vote_report_tx.sv - scoreboard bench for vote_report_tx with a UART decoding monitor
`timescale 1ns/1ps
module tb_vote_report_tx;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic       report_req = 1'b0;
    logic [7:0] cand1_vote = 8'd0;
    logic [7:0] cand2_vote = 8'd0;
    logic [7:0] cand3_vote = 8'd0;
    logic [7:0] cand4_vote = 8'd0;
    logic       tx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    vote_report_tx #(.CLKS_PER_BIT(N), .HEADER(8'hA5)) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .report_req (report_req),
        .cand1_vote (cand1_vote),
        .cand2_vote (cand2_vote),
        .cand3_vote (cand3_vote),
        .cand4_vote (cand4_vote),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Expected frame bytes are hand-supplied, including the checksum.
    task automatic push_frame(input logic [7:0] c1, c2, c3, c4, ck);
        exp_q.push_back(8'hA5);
        exp_q.push_back(c1);
        exp_q.push_back(c2);
        exp_q.push_back(c3);
        exp_q.push_back(c4);
        exp_q.push_back(ck);
    endtask

    task automatic set_tallies(input logic [7:0] c1, c2, c3, c4);
        cand1_vote = c1;
        cand2_vote = c2;
        cand3_vote = c3;
        cand4_vote = c4;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called at the sample point just after the accepting edge.
    task automatic run_frame(input bit perturb, input string name);
        int cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            step();
            if (perturb && cnt == 50) begin
                cand1_vote = 8'd9;
                mode       = 1'b0;
                report_req = 1'b1;
            end
            if (perturb && cnt == 51) report_req = 1'b0;
        end
        check({name, "_busy_cycles"}, cnt, 240);
        check({name, "_done_pulse"}, int'(done), 1);
    endtask

    // Monitor: decode 8N1 bytes from tx at mid-bit, compare against scoreboard.
    bit         rx_on = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'd0;
    always @(negedge clock) begin
        if (!reset) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on  = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % N == N / 2) begin
                if (rx_cnt / N == 0) begin
                    check("start_bit", int'(tx), 0);
                end else if (rx_cnt / N <= 8) begin
                    rx_byte[rx_cnt / N - 1] = tx;
                end else begin
                    check("stop_bit", int'(tx), 1);
                    rx_on = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(rx_byte), -1);
                    end else begin
                        check("frame_byte", int'(rx_byte), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        bit bad;

        // 1: reset held with toggling inputs
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            mode       = i[0];
            report_req = i[1];
            set_tallies(8'(i), 8'(i * 3), 8'(i + 7), 8'(255 - i));
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1;
        end
        check("reset_outputs_held", int'(bad), 0);
        report_req = 1'b0;
        mode       = 1'b0;
        reset      = 1'b1;
        step();
        check("post_reset_tx", int'(tx), 1);
        check("post_reset_busy", int'(busy), 0);

        // 2: basic frame
        mode = 1'b1;
        set_tallies(8'd3, 8'd0, 8'd7, 8'd255);
        push_frame(8'd3, 8'd0, 8'd7, 8'd255, 8'h09);
        report_req = 1'b1;
        step();
        report_req = 1'b0;
        check("accept_busy", int'(busy), 1);
        check("accept_tx_start", int'(tx), 0);
        run_frame(0, "basic");
        step();
        check("basic_done_one_cycle", int'(done), 0);

        // 3: requests ignored in voting mode
        mode       = 1'b0;
        report_req = 1'b1;
        bad        = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1;
        end
        report_req = 1'b0;
        check("mode0_ignored", int'(bad), 0);

        // 4: stability against mid-frame changes and busy requests
        mode = 1'b1;
        set_tallies(8'd3, 8'd0, 8'd7, 8'd255);
        push_frame(8'd3, 8'd0, 8'd7, 8'd255, 8'h09);
        report_req = 1'b1;
        step();
        report_req = 1'b0;
        run_frame(1, "stable");
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (busy !== 1'b0 || tx !== 1'b1) bad = 1;
        end
        check("no_second_frame", int'(bad), 0);
        check("stable_queue_drained", exp_q.size(), 0);

        // 5: mid-frame asynchronous reset
        mode = 1'b1;
        set_tallies(8'd1, 8'd2, 8'd3, 8'd4);
        push_frame(8'd1, 8'd2, 8'd3, 8'd4, 8'h0A);
        report_req = 1'b1;
        step();
        report_req = 1'b0;
        repeat (90) step();
        check("midframe_busy_before", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_tx", int'(tx), 1);
        check("async_reset_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) step();
        reset = 1'b1;
        step();
        check("after_release_busy", int'(busy), 0);
        set_tallies(8'd10, 8'd20, 8'd30, 8'd40);
        push_frame(8'd10, 8'd20, 8'd30, 8'd40, 8'h64);
        report_req = 1'b1;
        step();
        report_req = 1'b0;
        run_frame(0, "fresh");
        repeat (5) step();

        // 6: all-zero tallies, request held across done
        set_tallies(8'd0, 8'd0, 8'd0, 8'd0);
        push_frame(8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        push_frame(8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        report_req = 1'b1;
        step();
        run_frame(0, "zero1");
        step();
        report_req = 1'b0;
        check("b2b_busy", int'(busy), 1);
        check("b2b_tx_start", int'(tx), 0);
        run_frame(0, "zero2");
        repeat (10) step();
        check("final_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
